// File: rtl/instr_mem_responder.sv
// Memory-side responder for the instruction fetch interface.
// Word-organised RAM with a side load port. Requests are granted
// combinationally (subject to an in-flight limit and an external
// throttle), and answered in order exactly LATENCY cycles after grant
// through a fixed-length shift pipeline.
module instr_mem_responder #(
    parameter int unsigned MEM_DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int unsigned LATENCY         = 1,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        instr_req,
    input  logic [31:0] instr_addr,
    output logic        instr_gnt,
    output logic [31:0] instr_rdata,
    output logic        instr_err,
    output logic        instr_valid,
    input  logic        gnt_hold,
    input  logic        load_we,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_wdata,
    output logic [2:0]  outstanding
);

    localparam int unsigned AW        = $clog2(MEM_DEPTH);
    localparam logic [29:0] DEPTH_W   = 30'(MEM_DEPTH);
    localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];
    localparam logic [2:0]  MAX_W     = 3'(MAX_OUTSTANDING);

    logic [31:0] mem [MEM_DEPTH];

    logic [29:0] fetch_word;
    logic [29:0] load_word;
    logic        fetch_hit;
    logic        load_hit;
    logic        accept;
    logic [31:0] fetch_data;
    logic [2:0]  slots_busy;

    logic [LATENCY-1:0]       pipe_vld;
    logic [LATENCY-1:0]       pipe_err;
    logic [LATENCY-1:0][31:0] pipe_data;

    // Byte-offset bits are don't-care on both ports.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{instr_addr[1:0], load_addr[1:0]};

    // Word offsets from the base; addresses below the base wrap to large
    // values and therefore fall out of range as well.
    assign fetch_word = instr_addr[31:2] - BASE_WORD;
    assign load_word  = load_addr[31:2] - BASE_WORD;
    assign fetch_hit  = (fetch_word < DEPTH_W);
    assign load_hit   = (load_word < DEPTH_W);

    // A response retiring this cycle frees its slot immediately, so a new
    // grant can be issued in the same cycle as instr_valid.
    assign slots_busy = outstanding - {2'b00, instr_valid};
    assign instr_gnt  = ~gnt_hold & (slots_busy < MAX_W);
    assign accept     = instr_req & instr_gnt;

    // Combinational read in the accept cycle; the load write lands at the
    // edge, so a same-cycle load to the same word is not visible here.
    assign fetch_data = fetch_hit ? mem[fetch_word[AW-1:0]] : 32'h0;

    // Side-port RAM write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (load_we && load_hit) begin
            mem[load_word[AW-1:0]] <= load_wdata;
        end
    end

    // Response shift pipeline; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pipe_vld  <= '0;
            pipe_err  <= '0;
            pipe_data <= '0;
        end else begin
            pipe_vld[0]  <= accept;
            pipe_err[0]  <= accept & ~fetch_hit;
            pipe_data[0] <= accept ? fetch_data : 32'h0;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_err[i]  <= pipe_err[i-1];
                pipe_data[i] <= pipe_data[i-1];
            end
        end
    end

    assign instr_valid = pipe_vld[LATENCY-1];
    assign instr_err   = pipe_vld[LATENCY-1] & pipe_err[LATENCY-1];
    assign instr_rdata = pipe_vld[LATENCY-1] ? pipe_data[LATENCY-1] : 32'h0;

    // In-flight counter: +1 on accept, -1 on retire, unchanged on both.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            outstanding <= 3'd0;
        end else begin
            case ({accept, instr_valid})
                2'b10:   outstanding <= outstanding + 3'd1;
                2'b01:   outstanding <= outstanding - 3'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Scoreboard bench for instr_mem_responder (LATENCY=3, MAX_OUTSTANDING=2).
// The stimulus side predicts grants from the number of requests still in
// flight and pushes expected responses with their due cycle; a separate
// monitor pops and compares whatever the DUT presents each cycle.
module tb_instr_mem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int unsigned LAT   = 3;
    localparam int unsigned MAXO  = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        instr_req = 1'b0;
    logic [31:0] instr_addr = '0;
    logic        instr_gnt;
    logic [31:0] instr_rdata;
    logic        instr_err;
    logic        instr_valid;
    logic        gnt_hold = 1'b0;
    logic        load_we = 1'b0;
    logic [31:0] load_addr = '0;
    logic [31:0] load_wdata = '0;
    logic [2:0]  outstanding;

    instr_mem_responder #(
        .MEM_DEPTH(DEPTH),
        .BASE_ADDR(BASE),
        .LATENCY(LAT),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .instr_req(instr_req),
        .instr_addr(instr_addr),
        .instr_gnt(instr_gnt),
        .instr_rdata(instr_rdata),
        .instr_err(instr_err),
        .instr_valid(instr_valid),
        .gnt_hold(gnt_hold),
        .load_we(load_we),
        .load_addr(load_addr),
        .load_wdata(load_wdata),
        .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned due;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mref [DEPTH];
    int unsigned cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic        mon_en = 1'b0;
    logic        dmy;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp_v);
        end
    endfunction

    function automatic logic in_range(logic [31:0] a);
        logic [31:0] w;
        w = (a - BASE) >> 2;
        return (w < DEPTH);
    endfunction

    function automatic logic [9:0] word_of(logic [31:0] a);
        logic [31:0] w;
        w = (a - BASE) >> 2;
        return w[9:0];
    endfunction

    // Monitor: every cycle, compare the presented response (or idle) with
    // the scoreboard head if it is due now, and the in-flight count.
    exp_t mon_e;
    always @(negedge clk) begin
        #1;
        if (mon_en) begin
            check("outstanding", 32'(outstanding), 32'(sb_q.size()));
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                mon_e = sb_q.pop_front();
                check("valid", 32'(instr_valid), 32'd1);
                check("rdata", instr_rdata, mon_e.data);
                check("err", 32'(instr_err), 32'(mon_e.err));
            end else begin
                check("valid_idle", 32'(instr_valid), 32'd0);
                check("rdata_idle", instr_rdata, 32'd0);
                check("err_idle", 32'(instr_err), 32'd0);
            end
        end
    end

    // One clock cycle of stimulus plus reference-model update.
    task automatic do_cycle(input logic rq, input logic [31:0] a, input logic h,
                            input logic we, input logic [31:0] la, input logic [31:0] wd,
                            input logic rn, output logic acc);
        logic exp_gnt;
        exp_t e;
        @(negedge clk);
        instr_req  = rq;
        instr_addr = a;
        gnt_hold   = h;
        load_we    = we;
        load_addr  = la;
        load_wdata = wd;
        reset_n    = rn;
        #2;
        acc = 1'b0;
        if (!rn) begin
            sb_q.delete();
        end else begin
            // Responses due this cycle were already retired by the monitor,
            // so the queue holds exactly the slots still occupied.
            exp_gnt = !h && (sb_q.size() < MAXO);
            if (mon_en) check("gnt", 32'(instr_gnt), 32'(exp_gnt));
            if (rq && exp_gnt) begin
                acc = 1'b1;
                e.due = cyc + LAT;
                if (in_range(a)) begin
                    e.data = mref[word_of(a)];
                    e.err  = 1'b0;
                end else begin
                    e.data = 32'h0;
                    e.err  = 1'b1;
                end
                sb_q.push_back(e);
            end
            if (we && in_range(la)) mref[word_of(la)] = wd;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) do_cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, dmy);
    endtask

    // Keep requesting one address until the model says it was accepted.
    task automatic fetch(input logic [31:0] a);
        logic acc;
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++)
            do_cycle(1'b1, a, 1'b0, 1'b0, '0, '0, 1'b1, acc);
        if (!acc) check("fetch_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic        acc;
        logic [31:0] a;
        logic [31:0] next_a;
        logic        rq, h, we, rn;
        logic [31:0] la, wd;
        int          r;

        repeat (2) do_cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, dmy);
        mon_en = 1'b1;

        // Fill RAM through the side port: word i = A000_0000 + i.
        for (int i = 0; i < DEPTH; i++)
            do_cycle(1'b0, '0, 1'b0, 1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b1, dmy);
        idle(2);

        // Back-to-back fetches 0x0, 0x4, 0x8.
        fetch(32'h0); fetch(32'h4); fetch(32'h8);
        idle(LAT + 1);

        // Continuous requests from 0x10: limit throttling, reopen on valid.
        next_a = 32'h10;
        for (int k = 0; k < 10; k++) begin
            do_cycle(1'b1, next_a, 1'b0, 1'b0, '0, '0, 1'b1, acc);
            if (acc) next_a = next_a + 4;
        end
        idle(LAT + 1);

        // Out-of-range just past the end, then the last word.
        fetch(32'h1000);
        fetch(32'hFFC);
        idle(LAT + 1);

        // Throttle held for 5 cycles, then released.
        repeat (5) do_cycle(1'b1, 32'h20, 1'b1, 1'b0, '0, '0, 1'b1, dmy);
        fetch(32'h20);
        idle(LAT + 1);

        // Same-cycle load and fetch of 0x40 reads old data; next sees new.
        do_cycle(1'b1, 32'h40, 1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, 1'b1, acc);
        check("same_cycle_accept", 32'(acc), 32'd1);
        fetch(32'h40);
        idle(LAT + 1);

        // Two in flight, then reset: responses are discarded.
        fetch(32'h44); fetch(32'h48);
        do_cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, dmy);
        fetch(32'h4C);
        idle(LAT + 2);

        // Randomised traffic.
        for (int k = 0; k < 3000; k++) begin
            r = $urandom_range(0, 9);
            if (r < 8)       a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(0, 3));
            else if (r == 8) a = 32'h1000 + 32'($urandom_range(0, 4095));
            else             a = $urandom;
            rq = ($urandom_range(0, 3) != 0);
            h  = ($urandom_range(0, 4) == 0);
            we = ($urandom_range(0, 9) == 0);
            la = ($urandom_range(0, 4) == 0) ? $urandom
                                             : 32'($urandom_range(0, DEPTH - 1) * 4);
            wd = $urandom;
            rn = ($urandom_range(0, 149) != 0);
            if (!rn) begin
                rq = 1'b0;
                we = 1'b0;
            end
            do_cycle(rq, a, h, we, la, wd, rn, dmy);
        end
        idle(LAT + 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
